// File: rtl/pkg_cpu.sv
// pkg_cpu: shared ALU opcode, shifter kind, flag positions and ALU I/O structs
package pkg_cpu;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_ADC, ALU_SUB, ALU_SBC,
        ALU_AND, ALU_ORR, ALU_XOR, ALU_NOT,
        ALU_LSL, ALU_LSR, ALU_ASR, ALU_ROL,
        ALU_ROR, ALU_CPY, ALU_SEXTB, ALU_SEXTH
    } AluOper;
    // Shift kinds line up with the low three opcode bits of LSL..ROR
    typedef enum logic [2:0] {SH_LSL, SH_LSR, SH_ASR, SH_ROL, SH_ROR} ShiftKind;
    localparam int FlagZ = 0;
    localparam int FlagC = 1;
    localparam int FlagV = 2;
    localparam int FlagN = 3;
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        AluOper      oper;
        logic [3:0]  flags;
    } StrcInAlu;
    typedef struct packed {
        logic [31:0] result;
        logic [3:0]  flags;
    } StrcOutAlu;
endpackage

// File: rtl/alu_shifter.sv
// alu_shifter: combinational LSL/LSR/ASR, plus ROL/ROR when CPU_ALU_ROTATE_EN is defined
module alu_shifter
    import pkg_cpu::*;
(
    input  logic [31:0] value,
    input  logic [4:0]  amount,
    input  ShiftKind    kind,
    input  logic        carry_in,
    output logic [31:0] result,
    output logic        carry_out
);
    logic [32:0] lsl, lsr, asr;
    // Extra bit catches the last bit shifted out
    assign lsl = {1'b0, value} << amount;
    assign lsr = {value, 1'b0} >> amount;
    assign asr = $signed({value, 1'b0}) >>> amount;
`ifdef CPU_ALU_ROTATE_EN
    logic [31:0] rol, ror;
    assign rol = (value << amount) | (value >> (6'd32 - {1'b0, amount}));
    assign ror = (value >> amount) | (value << (6'd32 - {1'b0, amount}));
`endif
    always_comb begin
        result = value;
        carry_out = carry_in;
        if (amount != 5'd0) begin
            case (kind)
                SH_LSL: {carry_out, result} = lsl;
                SH_LSR: {result, carry_out} = lsr;
                SH_ASR: {result, carry_out} = asr;
`ifdef CPU_ALU_ROTATE_EN
                SH_ROL: {result, carry_out} = {rol, rol[0]};
                SH_ROR: {result, carry_out} = {ror, ror[31]};
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/alu.sv
// alu: registered single-cycle 32-bit ALU; CPU_ALU_ROTATE_EN enables ROL/ROR (else they copy a)
module alu
    import pkg_cpu::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  oper,
    input  logic [3:0]  flags_in,
    output logic        out_valid,
    output logic [31:0] result,
    output logic [3:0]  flags_out
);
    StrcInAlu    in_s;
    StrcOutAlu   nxt, out_q;
    logic [31:0] eff_b, sh_res;
    logic [32:0] sum;
    logic        add_cin, sh_c, c, v, unused_flags;
    assign in_s = '{a: a, b: b, oper: AluOper'(oper), flags: flags_in};
    assign unused_flags = ^{in_s.flags[FlagZ], in_s.flags[FlagN]};
    assign eff_b = in_s.oper inside {ALU_SUB, ALU_SBC} ? ~in_s.b : in_s.b;
    assign add_cin = in_s.oper == ALU_ADD ? 1'b0 : in_s.oper == ALU_SUB ? 1'b1 : in_s.flags[FlagC];
    assign sum = {1'b0, in_s.a} + {1'b0, eff_b} + {32'd0, add_cin};
    alu_shifter u_shifter (
        .value     (in_s.a),
        .amount    (in_s.b[4:0]),
        .kind      (ShiftKind'(oper[2:0])),
        .carry_in  (in_s.flags[FlagC]),
        .result    (sh_res),
        .carry_out (sh_c)
    );
    always_comb begin
        nxt.result = in_s.a;
        c = in_s.flags[FlagC];
        v = in_s.flags[FlagV];
        case (in_s.oper)
            ALU_ADD, ALU_ADC, ALU_SUB, ALU_SBC: begin
                nxt.result = sum[31:0];
                c = sum[32];
                v = (in_s.a[31] == eff_b[31]) && (sum[31] != in_s.a[31]);
            end
            ALU_AND:   nxt.result = in_s.a & in_s.b;
            ALU_ORR:   nxt.result = in_s.a | in_s.b;
            ALU_XOR:   nxt.result = in_s.a ^ in_s.b;
            ALU_NOT:   nxt.result = ~in_s.a;
`ifdef CPU_ALU_ROTATE_EN
            ALU_LSL, ALU_LSR, ALU_ASR, ALU_ROL, ALU_ROR: {nxt.result, c} = {sh_res, sh_c};
`else
            ALU_LSL, ALU_LSR, ALU_ASR: {nxt.result, c} = {sh_res, sh_c};
`endif
            ALU_CPY:   nxt.result = in_s.b;
            ALU_SEXTB: nxt.result = {{24{in_s.a[7]}}, in_s.a[7:0]};
            ALU_SEXTH: nxt.result = {{16{in_s.a[15]}}, in_s.a[15:0]};
            default: ;
        endcase
        nxt.flags[FlagZ] = nxt.result == 32'd0;
        nxt.flags[FlagC] = c;
        nxt.flags[FlagV] = v;
        nxt.flags[FlagN] = nxt.result[31];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_q <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) out_q <= nxt;
        end
    end
    assign result = out_q.result;
    assign flags_out = out_q.flags;
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed and randomized checks of alu against a bit-serial behavioural model
module tb_alu;
    logic        clk = 1'b0;
    logic        rst, in_valid, out_valid;
    logic [31:0] a, b, result;
    logic [3:0]  oper, flags_in, flags_out;
    int          checks = 0;
    int          errors = 0;
    alu dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .oper      (oper),
        .flags_in  (flags_in),
        .out_valid (out_valid),
        .result    (result),
        .flags_out (flags_out)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask
    // Returns {N,V,C,Z,result}; shifts are done one bit at a time
    function automatic logic [35:0] ref_alu(input logic [31:0] x, input logic [31:0] y,
                                            input logic [3:0] op, input logic [3:0] f);
        logic [31:0] r, eb;
        logic        c, v;
        longint      us, ss;
        int          cin, n;
        r = x;
        c = f[1];
        v = f[2];
        n = int'(y[4:0]);
        if (op <= 4'd3) begin
            eb = op >= 4'd2 ? ~y : y;
            cin = op == 4'd0 ? 0 : op == 4'd2 ? 1 : int'(f[1]);
            us = longint'(x) + longint'(eb) + cin;
            ss = longint'($signed(x)) + longint'($signed(eb)) + cin;
            r = us[31:0];
            c = us[32];
            v = ss > 64'sd2147483647 || ss < -64'sd2147483648;
        end else if (op == 4'd4) r = x & y;
        else if (op == 4'd5) r = x | y;
        else if (op == 4'd6) r = x ^ y;
        else if (op == 4'd7) r = ~x;
        else if (op == 4'd13) r = y;
        else if (op == 4'd14) r = 32'($signed(x[7:0]));
        else if (op == 4'd15) r = 32'($signed(x[15:0]));
        else begin
`ifndef CPU_ALU_ROTATE_EN
            if (op >= 4'd11) n = 0;
`endif
            for (int i = 0; i < n; i++) begin
                case (op)
                    4'd8:  begin c = r[31]; r = r << 1; end
                    4'd9:  begin c = r[0]; r = r >> 1; end
                    4'd10: begin c = r[0]; r = {r[31], r[31:1]}; end
                    4'd11: begin r = {r[30:0], r[31]}; c = r[0]; end
                    default: begin r = {r[0], r[31:1]}; c = r[31]; end
                endcase
            end
        end
        return {r[31], v, c, r == 32'd0, r};
    endfunction
    task automatic issue(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                         input logic [3:0] op, input logic [3:0] fi,
                         input logic [31:0] er, input logic [3:0] ef);
        a = ia;
        b = ib;
        oper = op;
        flags_in = fi;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_result"}, result, er);
        chk({tag, "_flags"}, 32'(flags_out), 32'(ef));
    endtask
    task automatic idle(input string tag);
        logic [31:0] r0;
        logic [3:0]  f0;
        r0 = result;
        f0 = flags_out;
        in_valid = 1'b0;
        a = $urandom;
        @(posedge clk);
        #1;
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_hold_r"}, result, r0);
        chk({tag, "_hold_f"}, 32'(flags_out), 32'(f0));
    endtask
    initial begin
        logic [35:0] m;
        logic [31:0] ra, rb;
        logic [3:0]  rop, rf;
        rst = 1'b1;
        in_valid = 1'b1;
        a = 32'd1;
        b = 32'd1;
        oper = 4'd0;
        flags_in = 4'd0;
        @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_flags", 32'(flags_out), 32'd0);
        rst = 1'b0;
        in_valid = 1'b0;
        idle("post_rst");
        issue("add_wrap", 32'hFFFF_FFFF, 32'h1, 4'd0, 4'b0000, 32'h0, 4'b0011);
        issue("add_ovf", 32'h7FFF_FFFF, 32'h1, 4'd0, 4'b0000, 32'h8000_0000, 4'b1100);
        issue("sub_neg", 32'd5, 32'd7, 4'd2, 4'b0000, 32'hFFFF_FFFE, 4'b1000);
        issue("sbc", 32'd10, 32'd3, 4'd3, 4'b0000, 32'd6, 4'b0010);
        issue("lsl1", 32'h8000_0001, 32'd1, 4'd8, 4'b0000, 32'h2, 4'b0010);
        issue("lsr0", 32'h1234_5678, 32'd0, 4'd9, 4'b0010, 32'h1234_5678, 4'b0010);
        issue("asr31", 32'h8000_0000, 32'd31, 4'd10, 4'b0000, 32'hFFFF_FFFF, 4'b1000);
`ifdef CPU_ALU_ROTATE_EN
        issue("ror1", 32'h1, 32'd1, 4'd12, 4'b0000, 32'h8000_0000, 4'b1010);
`else
        issue("ror1", 32'h1, 32'd1, 4'd12, 4'b0000, 32'h1, 4'b0000);
`endif
        issue("b2b_and", 32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'd4, 4'b0110, 32'h00F0_00F0, 4'b0110);
        issue("b2b_orr", 32'hF000_0000, 32'h0000_000F, 4'd5, 4'b0110, 32'hF000_000F, 4'b1110);
        issue("b2b_sextb", 32'h0000_0080, 32'h0, 4'd14, 4'b0110, 32'hFFFF_FF80, 4'b1110);
        idle("idle1");
        for (int i = 0; i < 400; i++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            rop = 4'($urandom_range(0, 15));
            rf = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) ra = {$urandom_range(0, 1) == 0 ? 32'h7FFF_FFFF : 32'hFFFF_FFFF};
            m = ref_alu(ra, rb, rop, rf);
            issue($sformatf("rnd%0d_op%0d", i, rop), ra, rb, rop, rf, m[31:0], m[35:32]);
            if ($urandom_range(0, 9) == 0) idle($sformatf("rnd%0d_idle", i));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
